// File: rtl/horizontal_window.sv
// horizontal_window: six-tap horizontal chroma window (im3..ip2) with edge replication; ports: clk, reset, in_valid/in_data/in_sol/in_eol/in_ready sample input, out_ready/out_valid/im3..ip2/out_sol/out_eol window output, line_err protocol pulse
module horizontal_window (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  input  logic       in_sol,
  input  logic       in_eol,
  output logic       in_ready,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [7:0] im3,
  output logic [7:0] im2,
  output logic [7:0] im1,
  output logic [7:0] i,
  output logic [7:0] ip1,
  output logic [7:0] ip2,
  output logic       out_sol,
  output logic       out_eol,
  output logic       line_err
);
  typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;
  state_t state;
  logic [5:0][7:0] w;
  logic [11:0] cnt, cnt_inc;
  logic [1:0] flush_cnt;
  logic adv, acc;
  assign adv = !out_valid | out_ready;
  assign in_ready = adv & (state != FLUSH);
  assign acc = in_valid & in_ready;
  assign cnt_inc = &cnt ? cnt : cnt + 12'd1;
  assign {ip2, ip1, i, im1, im2, im3} = w;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      w <= '0;
      cnt <= '0;
      flush_cnt <= '0;
      out_valid <= 1'b0;
      out_sol <= 1'b0;
      out_eol <= 1'b0;
      line_err <= 1'b0;
    end else begin
      line_err <= 1'b0;
      if (adv) begin
        out_valid <= 1'b0;
        out_sol <= 1'b0;
        out_eol <= 1'b0;
        if (state == FLUSH) begin
          if (flush_cnt != 2'd0) begin
            w <= {w[5], w[5:1]};
            out_valid <= 1'b1;
            out_sol <= cnt == {10'd0, flush_cnt};
            out_eol <= flush_cnt == 2'd1;
            flush_cnt <= flush_cnt - 2'd1;
          end
          if (flush_cnt <= 2'd1) state <= IDLE;
        end else if (acc) begin
          if (in_sol) begin
            line_err <= state != IDLE;
            w <= {6{in_data}};
            cnt <= 12'd1;
            flush_cnt <= {1'b0, in_eol};
            state <= in_eol ? FLUSH : FILL;
          end else if (state == IDLE) begin
            line_err <= 1'b1;
          end else begin
            w <= {in_data, w[5:1]};
            cnt <= cnt_inc;
            out_valid <= cnt >= 12'd2;
            out_sol <= cnt == 12'd2;
            flush_cnt <= in_eol ? 2'd2 : 2'd0;
            state <= in_eol ? FLUSH : RUN;
          end
        end
      end
    end
endmodule

// File: tb/tb_horizontal_window.sv
// tb_horizontal_window: directed and randomized checks of horizontal_window against a clamp-index window model
module tb_horizontal_window;
  logic clk, reset, in_valid, in_sol, in_eol, in_ready, out_ready, out_valid;
  logic out_sol, out_eol, line_err;
  logic [7:0] in_data, im3, im2, im1, i, ip1, ip2;
  typedef struct packed {
    logic [47:0] taps;
    logic sol;
    logic eol;
  } win_t;
  win_t expq[$];
  logic [7:0] cur[$];
  bit in_line;
  int checks, errors;
  horizontal_window dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_sol(in_sol),
    .in_eol(in_eol), .in_ready(in_ready), .out_ready(out_ready), .out_valid(out_valid),
    .im3(im3), .im2(im2), .im1(im1), .i(i), .ip1(ip1), .ip2(ip2),
    .out_sol(out_sol), .out_eol(out_eol), .line_err(line_err)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  function automatic logic [47:0] win_obs();
    return {ip2, ip1, i, im1, im2, im3};
  endfunction
  function automatic win_t mkwin(int n, int len);
    win_t r;
    int idx;
    for (int k = 0; k < 6; k++) begin
      idx = n + k - 3;
      if (idx < 0) idx = 0;
      if (len > 0 && idx > len - 1) idx = len - 1;
      r.taps[k*8 +: 8] = cur[idx];
    end
    r.sol = n == 0;
    r.eol = len > 0 && n == len - 1;
    return r;
  endfunction
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic model(input logic [7:0] d, input logic s, input logic e, output logic err);
    int n;
    err = 1'b0;
    if (s) begin
      err = in_line;
      cur.delete();
      in_line = 1;
    end else if (!in_line) begin
      err = 1'b1;
      return;
    end
    cur.push_back(d);
    n = cur.size();
    if (e) begin
      for (int k = (n >= 3 ? n - 3 : 0); k < n; k++) expq.push_back(mkwin(k, n));
      in_line = 0;
    end else if (n >= 3) expq.push_back(mkwin(n - 3, 0));
  endtask
  task automatic cycle(input logic v, input logic [7:0] d, input logic s, input logic e,
                       input logic r, output logic acc);
    win_t x;
    logic err;
    in_valid = v;
    in_data = d;
    in_sol = s;
    in_eol = e;
    out_ready = r;
    #1;
    if (out_valid && !r) chk("ready_stall", in_ready, 0);
    acc = v && in_ready;
    if (out_valid && r) begin
      if (expq.size() == 0) chk("extra_window", out_valid, 0);
      else begin
        x = expq.pop_front();
        chk("taps", win_obs(), x.taps);
        chk("sol", out_sol, x.sol);
        chk("eol", out_eol, x.eol);
      end
    end
    err = 1'b0;
    if (acc) model(d, s, e, err);
    @(posedge clk);
    #1;
    chk("line_err", line_err, err);
  endtask
  task automatic send(input logic [7:0] d, input logic s, input logic e, input int pr);
    logic acc;
    acc = 1'b0;
    for (int t = 0; t < 64 && !acc; t++) cycle(1'b1, d, s, e, $urandom_range(0, 99) < pr, acc);
    chk("send_timeout", acc, 1);
  endtask
  task automatic idle(input int n, input logic r);
    logic a;
    repeat (n) cycle(1'b0, 8'd0, 1'b0, 1'b0, r, a);
  endtask
  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_sol", out_sol, 0);
    chk("rst_eol", out_eol, 0);
    chk("rst_err", line_err, 0);
    chk("rst_win", win_obs(), 0);
    expq.delete();
    cur.delete();
    in_line = 0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("rst_ready", in_ready, 1);
  endtask
  initial begin
    logic a;
    reset = 1'b0;
    in_valid = 1'b0;
    in_data = 8'd0;
    in_sol = 1'b0;
    in_eol = 1'b0;
    out_ready = 1'b0;
    checks = 0;
    errors = 0;
    #1;
    do_reset();
    send(8'd10, 1, 0, 100);
    chk("lat_x0", out_valid, 0);
    send(8'd20, 0, 0, 100);
    chk("lat_x1", out_valid, 0);
    send(8'd30, 0, 0, 100);
    chk("lat_x2", out_valid, 1);
    chk("w0", win_obs(), {8'd30, 8'd20, 8'd10, 8'd10, 8'd10, 8'd10});
    chk("w0_sol", out_sol, 1);
    send(8'd40, 0, 0, 100);
    send(8'd50, 0, 1, 100);
    chk("flush_rdy0", in_ready, 0);
    idle(1, 1);
    chk("flush_rdy1", in_ready, 0);
    chk("flush_valid", out_valid, 1);
    idle(1, 1);
    chk("w4", win_obs(), {8'd50, 8'd50, 8'd50, 8'd40, 8'd30, 8'd20});
    chk("w4_eol", out_eol, 1);
    chk("flush_done", in_ready, 1);
    idle(1, 1);
    chk("l5_drained", out_valid, 0);
    chk("l5_count", expq.size(), 0);
    send(8'd77, 1, 1, 100);
    chk("l1_rdy", in_ready, 0);
    chk("l1_nowin", out_valid, 0);
    idle(1, 1);
    chk("l1_win", {win_obs(), out_sol, out_eol}, {{6{8'd77}}, 2'b11});
    chk("l1_idle", in_ready, 1);
    idle(1, 1);
    chk("l1_count", expq.size(), 0);
    send(8'd5, 1, 0, 100);
    send(8'd9, 0, 1, 100);
    chk("l2_rdy0", in_ready, 0);
    idle(1, 1);
    chk("l2_rdy1", in_ready, 0);
    chk("l2_w0", win_obs(), {8'd9, 8'd9, 8'd5, 8'd5, 8'd5, 8'd5});
    idle(1, 1);
    chk("l2_w1", win_obs(), {8'd9, 8'd9, 8'd9, 8'd5, 8'd5, 8'd5});
    chk("l2_rdy2", in_ready, 1);
    idle(1, 1);
    chk("l2_count", expq.size(), 0);
    send(8'd10, 1, 0, 100);
    send(8'd20, 0, 0, 100);
    send(8'd30, 0, 0, 100);
    for (int k = 0; k < 3; k++) begin
      cycle(1'b1, 8'd40, 1'b0, 1'b0, 1'b0, a);
      chk("stall_acc", a, 0);
      chk("stall_hold", win_obs(), {8'd30, 8'd20, 8'd10, 8'd10, 8'd10, 8'd10});
    end
    send(8'd40, 0, 0, 100);
    send(8'd50, 0, 1, 100);
    idle(3, 1);
    chk("stall_count", expq.size(), 0);
    cycle(1'b1, 8'd55, 1'b0, 1'b0, 1'b1, a);
    chk("orphan_err", line_err, 1);
    chk("orphan_nowin", out_valid, 0);
    send(8'd1, 1, 0, 100);
    send(8'd2, 0, 0, 100);
    send(8'd3, 0, 0, 100);
    send(8'd100, 1, 0, 100);
    chk("restart_err", line_err, 1);
    chk("restart_nowin", out_valid, 0);
    send(8'd101, 0, 0, 100);
    send(8'd102, 0, 1, 100);
    idle(3, 1);
    chk("restart_count", expq.size(), 0);
    send(8'd1, 1, 0, 100);
    send(8'd2, 0, 0, 100);
    send(8'd3, 0, 1, 100);
    chk("pre_rst_valid", out_valid, 1);
    do_reset();
    idle(2, 1);
    chk("post_rst_nowin", out_valid, 0);
    send(8'd8, 1, 0, 100);
    send(8'd8, 0, 0, 100);
    send(8'd8, 0, 1, 100);
    chk("l8_w0", win_obs(), {6{8'd8}});
    idle(3, 1);
    chk("l8_count", expq.size(), 0);
    for (int ln = 0; ln < 30; ln++) begin
      int len;
      len = $urandom_range(1, 8);
      if ($urandom_range(0, 9) == 0) send(8'($urandom), 0, 0, 70);
      for (int k = 0; k < len; k++) begin
        if ($urandom_range(0, 4) == 0) idle(1, 1'($urandom_range(0, 1)));
        send(8'($urandom), k == 0, k == len - 1, 70);
      end
    end
    idle(12, 1);
    chk("rand_drain", expq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/horizontal_window.md
HORIZONTAL_WINDOW -- requirements
Module: horizontal_window

Interface
REQ-001 SHALL have ports in this order: clk, reset, then the data ports below; one clock, reset asynchronous active-high.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous active-high reset.
REQ-004 in_valid  input  1  in_data valid this cycle.
REQ-005 in_data  input  8  chroma sample, one per transfer, raster order.
REQ-006 in_sol  input  1  qualifies in_data as first sample of a line.
REQ-007 in_eol  input  1  qualifies in_data as last sample of a line; may coincide with in_sol.
REQ-008 in_ready  output  1  block accepts a transfer when in_valid&in_ready.
REQ-009 out_ready  input  1  downstream filter stage consumes the window when out_valid&out_ready.
REQ-010 out_valid  output  1  window outputs valid.
REQ-011 im3, im2, im1, i, ip1, ip2  output  8 each  six-tap window centred on i, ordered oldest to newest.
REQ-012 out_sol, out_eol  output  1 each  window is the first / last of its line.
REQ-013 line_err  output  1  one-cycle pulse on protocol error.

Function
REQ-014 Window: six 8-bit registers W0..W5 that drive im3..ip2; a "shift" moves each register one place toward im3 and loads a new value into ip2.
REQ-015 States: IDLE, FILL, RUN, FLUSH.
REQ-016 Advance condition: adv = !out_valid | out_ready; no window register changes when adv=0.
REQ-017 in_ready = adv & (state != FLUSH).
REQ-018 IDLE, accepted in_sol sample x0: load all six registers with x0; set cnt=1; go FILL, or go FLUSH with flush_cnt=1 if in_eol is also set.
REQ-019 IDLE, accepted sample without in_sol: discard it, pulse line_err, stay IDLE.
REQ-020 FILL/RUN, accepted sample without in_sol: shift it in; cnt = cnt+1, saturating at 4095.
REQ-021 In FILL/RUN, a shift SHALL assert out_valid next cycle when the pre-increment cnt >= 2; out_valid is then centred on sample cnt-2.
REQ-022 FILL goes to RUN when cnt reaches 2.
REQ-023 FILL/RUN, accepted sample with in_eol: shift and output per REQ-020/021, then go FLUSH with flush_cnt = min(cnt_after, 2).
REQ-024 FLUSH: while flush_cnt != 0 and adv, shift in a copy of the current ip2 (right-edge replication), assert out_valid, and decrement flush_cnt; go IDLE after the final flush shift.
REQ-025 FILL/RUN, accepted in_sol (line restart): pulse line_err, drop the unfinished line without flushing it, reload per REQ-018.
REQ-026 out_sol SHALL be 1 on the first window of a line (centre = x0); out_eol SHALL be 1 on the last window (centre = x(L-1)).
REQ-027 For a line of length L >= 1, exactly L windows SHALL be emitted; window n has tap value x(clamp(n+k, 0, L-1)) for k = -3..+2.
REQ-028 Latency: the window centred on xn becomes valid the cycle after x(n+2) is accepted, or the cycle after a flush shift; once valid it is held stable until consumed.
REQ-029 Full throughput: with out_ready=1 continuously, one sample is accepted per cycle in FILL/RUN; FLUSH adds exactly min(L,2) cycles per line with in_ready=0.
REQ-030 All outputs are registered; no combinational path from in_* to out_*; the only combinational path is out_ready -> in_ready.

Reset
REQ-031 On reset: state=IDLE; out_valid=0; out_sol=0; out_eol=0; line_err=0; W0..W5=0; cnt=0; flush_cnt=0; in_ready=1 after reset release.
REQ-032 Reset asserted mid-line or mid-flush SHALL abandon the line immediately; no window is emitted for it afterward.

Verification
REQ-033 Line 10,20,30,40,50 with out_ready=1 -> 5 windows with centres 10..50; window0 = 10,10,10,10,20,30 (out_sol=1); window4 = 20,30,40,50,50,50 (out_eol=1).
REQ-034 L=1, sample 77 with sol=eol=1 -> one window of all 77, out_sol=out_eol=1, then IDLE.
REQ-035 L=2 (5, 9) -> windows 5,5,5,5,9,9 and 5,5,5,9,9,9; in_ready=0 for two cycles.
REQ-036 Hold out_ready=0 for 3 cycles mid-line -> window held unchanged, in_ready=0, no samples lost, same output sequence as REQ-033.
REQ-037 Sample without sol in IDLE -> line_err pulse, no window emitted; sol arriving at cnt=3 -> line_err pulse, new line windows correct, old line truncated.
REQ-038 Assert reset during FLUSH of line 1,2,3 -> out_valid=0 immediately; next line 8,8,8 -> three windows of all 8.
